// File: rtl/kv_cache_pkg.sv
// Shared types and helpers for the cache replacement logic.
package kv_cache_pkg;

  typedef enum logic [0:0] {
    PlruInit,
    PlruRun
  } plru_state_e;

  // A binary tree over N leaves has N-1 internal nodes.
  function automatic int unsigned plru_bit_num(int unsigned way_num);
    return way_num - 1;
  endfunction

  // Index of the lowest set bit; an all-zero input maps to 0.
  function automatic int unsigned onehot_to_idx(logic [31:0] onehot);
    int unsigned idx = 0;
    for (int i = 31; i >= 0; i--) begin
      if (onehot[i[4:0]]) idx = unsigned'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/kv_plru_tree.sv
// Combinational tree-PLRU logic for one set: victim walk and touch update.
module kv_plru_tree
  import kv_cache_pkg::*;
#(
  parameter int unsigned WayNum = 4
) (
  input  logic [plru_bit_num(WayNum)-1:0] bits_i,
  input  logic [WayNum-1:0]               way_i,
  output logic [WayNum-1:0]               victim_o,
  output logic [plru_bit_num(WayNum)-1:0] bits_o,
  output logic [plru_bit_num(WayNum)-1:0] path_o
);

  localparam int unsigned NodeNum  = plru_bit_num(WayNum);
  localparam int unsigned LevelNum = $clog2(WayNum);

  function automatic logic [WayNum-1:0] walk(logic [NodeNum-1:0] bits);
    int unsigned         node = 0;
    logic [NodeNum-1:0]  sh;
    for (int l = 0; l < LevelNum; l++) begin
      sh   = bits >> node;
      node = 2 * node + (sh[0] ? 2 : 1);
    end
    return WayNum'(1) << (node - NodeNum);
  endfunction

  // Marks every node between the root and the touched leaf.
  function automatic logic [NodeNum-1:0] path_of(logic [WayNum-1:0] way);
    int unsigned        idx  = onehot_to_idx(32'(way));
    int unsigned        node = 0;
    int unsigned        dir;
    logic [NodeNum-1:0] path = '0;
    for (int l = 0; l < LevelNum; l++) begin
      dir  = (idx >> (LevelNum - 1 - l)) & 1;
      path = path | (NodeNum'(1) << node);
      node = 2 * node + 1 + dir;
    end
    return path;
  endfunction

  // Each node on the path is pointed at the sibling subtree of the touched way.
  function automatic logic [NodeNum-1:0] update(logic [NodeNum-1:0] bits,
                                                logic [WayNum-1:0]  way);
    int unsigned        idx  = onehot_to_idx(32'(way));
    int unsigned        node = 0;
    int unsigned        dir;
    logic [NodeNum-1:0] mask;
    logic [NodeNum-1:0] res  = bits;
    for (int l = 0; l < LevelNum; l++) begin
      dir  = (idx >> (LevelNum - 1 - l)) & 1;
      mask = NodeNum'(1) << node;
      res  = (dir != 0) ? (res & ~mask) : (res | mask);
      node = 2 * node + 1 + dir;
    end
    return res;
  endfunction

  always_comb begin
    victim_o = walk(bits_i);
    bits_o   = update(bits_i, way_i);
    path_o   = path_of(way_i);
  end

endmodule

// File: rtl/kv_plru_victim_select.sv
// Per-set tree PLRU victim selector with invalid-way priority.
// Define KV_PLRU_AUTO_TOUCH_EN to make every issued victim also touch its set/way.
module kv_plru_victim_select
  import kv_cache_pkg::*;
#(
  parameter int unsigned WAY_NUM = 4,
  parameter int unsigned SET_NUM = 64,
  parameter int unsigned IDX_W   = $clog2(SET_NUM)
) (
  input  logic               i_clk,
  input  logic               i_rst,
  output logic               o_ready,
  input  logic               i_touch_valid,
  input  logic [IDX_W-1:0]   i_touch_idx,
  input  logic [WAY_NUM-1:0] i_touch_way,
  input  logic               i_victim_req,
  input  logic [IDX_W-1:0]   i_victim_idx,
  input  logic [WAY_NUM-1:0] i_valid_way,
  output logic               o_victim_valid,
  output logic [WAY_NUM-1:0] o_victim_way,
  output logic               o_victim_invalid
);

  localparam int unsigned NodeNum = plru_bit_num(WAY_NUM);

  plru_state_e        state_q, state_d;
  logic [IDX_W-1:0]   cnt_q, cnt_d;
  logic [NodeNum-1:0] tree_q [SET_NUM];

  logic               run;
  logic               all_valid;
  logic [WAY_NUM-1:0] invalid_way;
  logic [WAY_NUM-1:0] first_invalid;
  logic [WAY_NUM-1:0] plru_way;
  logic [WAY_NUM-1:0] victim_way_d;
  logic [WAY_NUM-1:0] auto_way;
  logic [NodeNum-1:0] auto_upd;
  logic [NodeNum-1:0] auto_path;
  logic [NodeNum-1:0] touch_bits;
  logic [WAY_NUM-1:0] touch_walk;
  logic [NodeNum-1:0] touch_path;

  assign run     = (state_q == PlruRun);
  assign o_ready = run;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      PlruInit: begin
        cnt_d = cnt_q + IDX_W'(1);
        if (cnt_q == IDX_W'(SET_NUM - 1)) state_d = PlruRun;
      end
      PlruRun: ;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= PlruInit;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Lowest-index invalid way wins over the PLRU choice.
  assign all_valid     = &i_valid_way;
  assign invalid_way   = ~i_valid_way;
  assign first_invalid = invalid_way & (~invalid_way + WAY_NUM'(1));
  assign victim_way_d  = all_valid ? plru_way : first_invalid;

`ifdef KV_PLRU_AUTO_TOUCH_EN
  assign auto_way = victim_way_d;
`else
  assign auto_way = '0;
`endif

  kv_plru_tree #(
    .WayNum (WAY_NUM)
  ) u_victim_tree (
    .bits_i   (tree_q[i_victim_idx]),
    .way_i    (auto_way),
    .victim_o (plru_way),
    .bits_o   (auto_upd),
    .path_o   (auto_path)
  );

  kv_plru_tree #(
    .WayNum (WAY_NUM)
  ) u_touch_tree (
    .bits_i   (tree_q[i_touch_idx]),
    .way_i    (i_touch_way),
    .victim_o (touch_walk),
    .bits_o   (touch_bits),
    .path_o   (touch_path)
  );

`ifdef KV_PLRU_AUTO_TOUCH_EN
  logic               same_set;
  logic [NodeNum-1:0] auto_bits;
  // Both paths land on a shared set; auto-touch owns any node on its own path.
  assign same_set  = i_touch_valid && (i_touch_idx == i_victim_idx);
  assign auto_bits = same_set ? ((touch_bits & ~auto_path) | (auto_upd & auto_path)) : auto_upd;

  logic unused_touch;
  assign unused_touch = ^{touch_walk, touch_path};
`else
  logic unused_tree_ports;
  assign unused_tree_ports = ^{touch_walk, touch_path, auto_upd, auto_path};
`endif

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      // Tree bits are not reset here; INIT clears them one set per cycle.
    end else if (!run) begin
      tree_q[cnt_q] <= '0;
    end else begin
      if (i_touch_valid) tree_q[i_touch_idx] <= touch_bits;
`ifdef KV_PLRU_AUTO_TOUCH_EN
      if (i_victim_req) tree_q[i_victim_idx] <= auto_bits;
`endif
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      o_victim_valid   <= 1'b0;
      o_victim_way     <= '0;
      o_victim_invalid <= 1'b0;
    end else begin
      o_victim_valid <= run && i_victim_req;
      if (run && i_victim_req) begin
        o_victim_way     <= victim_way_d;
        o_victim_invalid <= !all_valid;
      end
    end
  end

endmodule

// File: tb/tb_kv_plru_victim_select.sv
// Directed bench for kv_plru_victim_select with a 4-way, 64-set configuration.
module tb_kv_plru_victim_select;

  localparam int unsigned Ways = 4;
  localparam int unsigned Sets = 64;
  localparam int unsigned IdxW = 6;

  logic            clk;
  logic            i_rst;
  logic            o_ready;
  logic            i_touch_valid;
  logic [IdxW-1:0] i_touch_idx;
  logic [Ways-1:0] i_touch_way;
  logic            i_victim_req;
  logic [IdxW-1:0] i_victim_idx;
  logic [Ways-1:0] i_valid_way;
  logic            o_victim_valid;
  logic [Ways-1:0] o_victim_way;
  logic            o_victim_invalid;

  int errors = 0;
  int checks = 0;

  // Expected victim per valid pattern; 4'b1111 uses the PLRU state of set 5
  // after touching ways 0 then 2 (root=0, left=1, right=1 -> way 1).
  logic [3:0] exp_tab [16] = '{
    4'b0001, 4'b0010, 4'b0001, 4'b0100, 4'b0001, 4'b0010, 4'b0001, 4'b1000,
    4'b0001, 4'b0010, 4'b0001, 4'b0100, 4'b0001, 4'b0010, 4'b0001, 4'b0010
  };

  kv_plru_victim_select #(
    .WAY_NUM (Ways),
    .SET_NUM (Sets)
  ) dut (
    .i_clk            (clk),
    .i_rst            (i_rst),
    .o_ready          (o_ready),
    .i_touch_valid    (i_touch_valid),
    .i_touch_idx      (i_touch_idx),
    .i_touch_way      (i_touch_way),
    .i_victim_req     (i_victim_req),
    .i_victim_idx     (i_victim_idx),
    .i_valid_way      (i_valid_way),
    .o_victim_valid   (o_victim_valid),
    .o_victim_way     (o_victim_way),
    .o_victim_invalid (o_victim_invalid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic touch(input logic [IdxW-1:0] idx, input logic [Ways-1:0] way);
    i_touch_valid = 1'b1;
    i_touch_idx   = idx;
    i_touch_way   = way;
    tick();
    i_touch_valid = 1'b0;
  endtask

  task automatic victim(input string tag, input logic [IdxW-1:0] idx,
                        input logic [Ways-1:0] valid, input logic [Ways-1:0] exp_way,
                        input logic exp_inv);
    i_victim_req = 1'b1;
    i_victim_idx = idx;
    i_valid_way  = valid;
    tick();
    i_victim_req = 1'b0;
    check({tag, "_valid"}, o_victim_valid, 1);
    check({tag, "_way"}, o_victim_way, exp_way);
    check({tag, "_inv"}, o_victim_invalid, exp_inv);
  endtask

  initial begin
    i_rst         = 1'b1;
    i_touch_valid = 1'b0;
    i_touch_idx   = '0;
    i_touch_way   = '0;
    i_victim_req  = 1'b0;
    i_victim_idx  = '0;
    i_valid_way   = '0;
    repeat (3) tick();
    check("rst_ready", o_ready, 0);
    check("rst_valid", o_victim_valid, 0);
    check("rst_way", o_victim_way, 0);
    check("rst_inv", o_victim_invalid, 0);

    // Release reset with a request and a touch held high; both must be ignored in INIT.
    i_rst         = 1'b0;
    i_victim_req  = 1'b1;
    i_victim_idx  = 6'd5;
    i_valid_way   = 4'b1111;
    i_touch_valid = 1'b1;
    i_touch_idx   = 6'd0;
    i_touch_way   = 4'b0001;
    for (int c = 1; c <= 64; c++) begin
      tick();
      check("init_ready", o_ready, (c == 64));
      check("init_valid", o_victim_valid, 0);
    end
    check("init_way", o_victim_way, 0);
    i_victim_req  = 1'b0;
    i_touch_valid = 1'b0;

    victim("init_touch_ignored", 6'd0, 4'b1111, 4'b0001, 1'b0);
    victim("fresh", 6'd5, 4'b1111, 4'b0001, 1'b0);
    touch(6'd5, 4'b0001);
    victim("after_t0", 6'd5, 4'b1111, 4'b0100, 1'b0);
    touch(6'd5, 4'b0100);
    victim("after_t2", 6'd5, 4'b1111, 4'b0010, 1'b0);
    victim("inv_1011", 6'd5, 4'b1011, 4'b0100, 1'b1);

    // Back-to-back sweep of every valid pattern.
    i_victim_req = 1'b1;
    i_victim_idx = 6'd5;
    for (int p = 0; p < 16; p++) begin
      i_valid_way = 4'(p);
      tick();
      check("sweep_valid", o_victim_valid, 1);
      check("sweep_way", o_victim_way, exp_tab[4'(p)]);
      check("sweep_inv", o_victim_invalid, (p != 15));
    end
    i_victim_req = 1'b0;
    tick();
    check("idle_valid", o_victim_valid, 0);
    check("hold_way", o_victim_way, 4'b0010);
    check("hold_inv", o_victim_invalid, 0);

    // Same-set touch and request: the walk sees pre-touch state.
    i_touch_valid = 1'b1;
    i_touch_idx   = 6'd9;
    i_touch_way   = 4'b0001;
    victim("same_cycle", 6'd9, 4'b1111, 4'b0001, 1'b0);
    i_touch_valid = 1'b0;
    // A touch to another set must not disturb the walk of set 9.
    i_touch_valid = 1'b1;
    i_touch_idx   = 6'd10;
    i_touch_way   = 4'b0100;
    victim("post_touch", 6'd9, 4'b1111, 4'b0100, 1'b0);
    i_touch_valid = 1'b0;

    // Reset during an issued request drops the response and restarts INIT.
    i_rst        = 1'b1;
    i_victim_req = 1'b1;
    i_victim_idx = 6'd5;
    i_valid_way  = 4'b1111;
    tick();
    check("midrst_valid", o_victim_valid, 0);
    check("midrst_ready", o_ready, 0);
    i_rst        = 1'b0;
    i_victim_req = 1'b0;
    repeat (63) tick();
    check("reinit_not_ready", o_ready, 0);
    tick();
    check("reinit_ready", o_ready, 1);
    victim("reinit_set5", 6'd5, 4'b1111, 4'b0001, 1'b0);
    victim("reinit_set9", 6'd9, 4'b1111, 4'b0001, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
